// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: turns the free-running board clock plus raw step button and
// run switch inputs into a clean processor clock. The three modes are halted,
// single-step (one pulse per debounced press) and free-run (divided clock).
// It also counts processor clock rising edges.
//
// Both raw inputs are synchronized and debounced. A five-state FSM sequences
// the high and low phases. cpu_clk and busy are registered decodes of the FSM
// state, so they trail the state by one board cycle. This keeps the processor
// clock free of glitches and of any combinational path to the output.
module cpu_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RUN_DIV         = 4,
  parameter int PULSE_HIGH      = 2,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic             halt,
  output logic             cpu_clk,
  output logic [CNT_W-1:0] cycle_count,
  output logic             busy
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The phase counter covers the longer of the run half-period and the step pulse.
  localparam int PH_MAX = (RUN_DIV > PULSE_HIGH) ? RUN_DIV : PULSE_HIGH;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0] STEP_LAST = PH_W'(PULSE_HIGH - 1);
  localparam logic [PH_W-1:0] RUN_LAST  = PH_W'(RUN_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STEP_HI = 3'd1,
    ST_STEP_LO = 3'd2,
    ST_RUN_HI  = 3'd3,
    ST_RUN_LO  = 3'd4
  } state_t;

  // Index 0 is the step button and index 1 is the run switch.
  logic [1:0]      raw_s;
  logic [1:0]      sync1_r;
  logic [1:0]      sync2_r;
  logic [1:0]      stable_r;
  logic [DB_W-1:0] db_cnt_r [2];
  logic            step_stable_d_r;
  logic            step_req_s;
  logic            run_go_s;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [PH_W-1:0] ph_r;
  logic [PH_W-1:0] ph_nxt_s;

  logic            cpu_clk_nxt_s;
  logic            busy_nxt_s;
  logic            cpu_clk_r;
  logic            busy_r;
  logic [CNT_W-1:0] cycle_count_r;

  assign raw_s = {run_sw, step_btn};

  // Two-flop synchronizers for both asynchronous inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: the stable value follows the synchronized input only after it
  // has differed for DEBOUNCE_CYCLES consecutive edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_r[i] <= {DB_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          db_cnt_r[i] <= {DB_W{1'b0}};
        end else if (db_cnt_r[i] == DB_LAST) begin
          stable_r[i] <= sync2_r[i];
          db_cnt_r[i] <= {DB_W{1'b0}};
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
        end
      end
    end
  end

  // Delayed debounced step value, used to detect the press edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_stable_d_r <= 1'b0;
    end else begin
      step_stable_d_r <= stable_r[0];
    end
  end

  // A release produces no request; only the debounced rising edge does.
  assign step_req_s = stable_r[0] & ~step_stable_d_r;
  assign run_go_s   = stable_r[1] & ~halt;

  // FSM state and phase counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ph_r    <= {PH_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ph_r    <= ph_nxt_s;
    end
  end

  // Next-state logic. A started high phase always runs its full low phase.
  // Step requests that arrive while a pulse is in flight are dropped.
  always_comb begin
    state_nxt_s = state_r;
    ph_nxt_s    = ph_r + PH_W'(1);
    case (state_r)
      ST_IDLE: begin
        ph_nxt_s = {PH_W{1'b0}};
        if (run_go_s) begin
          state_nxt_s = ST_RUN_HI;
        end else if (step_req_s) begin
          state_nxt_s = ST_STEP_HI;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STEP_HI: begin
        if (ph_r == STEP_LAST) begin
          state_nxt_s = ST_STEP_LO;
          ph_nxt_s    = {PH_W{1'b0}};
        end else begin
          state_nxt_s = ST_STEP_HI;
        end
      end
      ST_STEP_LO: begin
        if (ph_r == STEP_LAST) begin
          state_nxt_s = ST_IDLE;
          ph_nxt_s    = {PH_W{1'b0}};
        end else begin
          state_nxt_s = ST_STEP_LO;
        end
      end
      ST_RUN_HI: begin
        if (ph_r == RUN_LAST) begin
          state_nxt_s = ST_RUN_LO;
          ph_nxt_s    = {PH_W{1'b0}};
        end else begin
          state_nxt_s = ST_RUN_HI;
        end
      end
      ST_RUN_LO: begin
        if (ph_r == RUN_LAST) begin
          ph_nxt_s = {PH_W{1'b0}};
          if (run_go_s) begin
            state_nxt_s = ST_RUN_HI;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_RUN_LO;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ph_nxt_s    = {PH_W{1'b0}};
      end
    endcase
  end

  // Output decode of the current state, registered below.
  always_comb begin
    cpu_clk_nxt_s = 1'b0;
    busy_nxt_s    = 1'b1;
    case (state_r)
      ST_IDLE:    busy_nxt_s    = 1'b0;
      ST_STEP_HI: cpu_clk_nxt_s = 1'b1;
      ST_RUN_HI:  cpu_clk_nxt_s = 1'b1;
      ST_STEP_LO: cpu_clk_nxt_s = 1'b0;
      ST_RUN_LO:  cpu_clk_nxt_s = 1'b0;
      default: begin
        cpu_clk_nxt_s = 1'b0;
        busy_nxt_s    = 1'b0;
      end
    endcase
  end

  // Registered outputs. The counter advances on the edge that raises cpu_clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_clk_r     <= 1'b0;
      busy_r        <= 1'b0;
      cycle_count_r <= {CNT_W{1'b0}};
    end else begin
      cpu_clk_r <= cpu_clk_nxt_s;
      busy_r    <= busy_nxt_s;
      if (cpu_clk_nxt_s && !cpu_clk_r) begin
        cycle_count_r <= cycle_count_r + CNT_W'(1);
      end else begin
        cycle_count_r <= cycle_count_r;
      end
    end
  end

  assign cpu_clk     = cpu_clk_r;
  assign busy        = busy_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Testbench for cpu_clock_ctrl. The reference model works from the behaviour
// rules directly:
//  - Each debouncer keeps a sliding window of synchronized samples and flips
//    when the last DEBOUNCE_CYCLES samples all disagree with the stable value.
//  - The clock generator is modelled as "pairs": one high phase plus one low
//    phase, tracked with a single position counter.
module tb_cpu_clock_ctrl;

  localparam int DB  = 4;
  localparam int RD  = 4;
  localparam int PH  = 2;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          step_btn;
  logic          run_sw;
  logic          halt;
  logic          cpu_clk;
  logic [CW-1:0] cycle_count;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_clock_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .RUN_DIV(RD),
    .PULSE_HIGH(PH),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .step_btn(step_btn),
    .run_sw(run_sw),
    .halt(halt),
    .cpu_clk(cpu_clk),
    .cycle_count(cycle_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_s1 [2];
  bit          m_s2 [2];
  bit          m_stable [2];
  bit          m_stable_d;
  bit          m_win0 [$];
  bit          m_win1 [$];
  bit          m_active;
  bit          m_is_run;
  int          m_pos;
  int          m_len;
  bit          m_hi;
  bit          m_cpu;
  bit          m_busy;
  logic [CW-1:0] m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_stable[i] = 1'b0;
    end
    m_stable_d = 1'b0;
    m_win0.delete(); m_win1.delete();
    m_active = 1'b0; m_is_run = 1'b0; m_pos = 0; m_len = 0; m_hi = 1'b0;
    m_cpu = 1'b0; m_busy = 1'b0; m_cnt = '0;
  endtask

  task automatic start_pair(input bit is_run);
    m_active = 1'b1;
    m_is_run = is_run;
    m_pos    = 0;
    m_len    = is_run ? 2 * RD : 2 * PH;
  endtask

  // Returns the new stable value after pushing one synchronized sample.
  function automatic bit window_push(ref bit win [$], input bit sample, input bit stable);
    bit all_differ;
    win.push_back(sample);
    if (win.size() > DB) void'(win.pop_front());
    all_differ = (win.size() == DB);
    foreach (win[k]) if (win[k] == stable) all_differ = 1'b0;
    if (all_differ) begin
      win.delete();
      return ~stable;
    end
    // A sample equal to the stable value breaks the streak.
    if (sample == stable) win.delete();
    return stable;
  endfunction

  task automatic model_step();
    bit step_req, run_go;
    step_req = m_stable[0] & ~m_stable_d;
    run_go   = m_stable[1] & ~halt;
    // Outputs show the previous cycle's state.
    if (m_hi && !m_cpu) m_cnt = m_cnt + 1'b1;
    m_cpu  = m_hi;
    m_busy = m_active;
    if (m_active) begin
      m_pos++;
      if (m_pos == m_len) begin
        m_active = 1'b0;
        if (m_is_run && run_go) start_pair(1'b1);
      end
    end else if (run_go) begin
      start_pair(1'b1);
    end else if (step_req) begin
      start_pair(1'b0);
    end
    m_hi = m_active && (m_pos < m_len / 2);
    m_stable_d  = m_stable[0];
    m_stable[0] = window_push(m_win0, m_s2[0], m_stable[0]);
    m_stable[1] = window_push(m_win1, m_s2[1], m_stable[1]);
    m_s2[0] = m_s1[0]; m_s2[1] = m_s1[1];
    m_s1[0] = step_btn; m_s1[1] = run_sw;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One board cycle: advance the model on the edge and compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    check_eq("cpu_clk", {31'd0, cpu_clk}, {31'd0, m_cpu});
    check_eq("busy", {31'd0, busy}, {31'd0, m_busy});
    check_eq("cycle_count", {28'd0, cycle_count}, {28'd0, m_cnt});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_cpu_high(input int budget);
    int t;
    t = 0;
    while (cpu_clk !== 1'b1 && t < budget) begin
      tick();
      t++;
    end
    check_eq("wait_cpu_high_timeout", {31'd0, cpu_clk}, 32'd1);
  endtask

  task automatic press(input int hold, input int rel);
    step_btn = 1'b1;
    ticks(hold);
    step_btn = 1'b0;
    ticks(rel);
  endtask

  initial begin
    int first_hi, hi_cyc, busy_cyc, cnt0, last_rise, streak;
    bit prev;

    // Reset with inputs active.
    rst_n = 1'b0; step_btn = 1'b1; run_sw = 1'b1; halt = 1'b0;
    model_reset();
    ticks(3);
    step_btn = 1'b0; run_sw = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks(6);

    // Clean step press: rises on the DB+4th sampled edge (edge DB+3).
    first_hi = -1; hi_cyc = 0; busy_cyc = 0;
    step_btn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (cpu_clk && first_hi < 0) first_hi = i;
      if (cpu_clk) hi_cyc++;
      if (busy) busy_cyc++;
    end
    step_btn = 1'b0;
    ticks(20);
    check_eq("step_latency", first_hi, DB + 4);
    check_eq("step_high_cycles", hi_cyc, PH);
    check_eq("step_busy_cycles", busy_cyc, 2 * PH);
    check_eq("step_count", {28'd0, cycle_count}, 32'd1);

    // Bounce rejection, then a clean press.
    cnt0 = cycle_count;
    for (int i = 0; i < 6; i++) begin
      step_btn = ~step_btn;
      ticks(2);
    end
    step_btn = 1'b0;
    ticks(20);
    check_eq("bounce_no_pulse", cycle_count, cnt0);
    press(12, 15);
    check_eq("after_bounce_press", cycle_count, (cnt0 + 1) % 16);

    // Free run: period 2*RD with RD high.
    cnt0 = cycle_count; last_rise = -1; streak = 0; prev = cpu_clk;
    run_sw = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cpu_clk && !prev) begin
        if (last_rise >= 0) check_eq("run_period", i - last_rise, 2 * RD);
        last_rise = i;
      end
      if (!cpu_clk && prev) check_eq("run_high_len", streak, RD);
      streak = cpu_clk ? streak + 1 : 0;
      prev = cpu_clk;
    end
    run_sw = 1'b0;
    ticks(30);
    check_eq("run_stop_low", {31'd0, cpu_clk}, 32'd0);
    check_eq("run_stop_idle", {31'd0, busy}, 32'd0);

    // Halt during a high phase.
    run_sw = 1'b1;
    wait_cpu_high(40);
    halt = 1'b1;
    ticks(30);
    check_eq("halt_low", {31'd0, cpu_clk}, 32'd0);
    check_eq("halt_idle", {31'd0, busy}, 32'd0);
    cnt0 = cycle_count;
    press(12, 15);
    check_eq("halt_step", cycle_count, (cnt0 + 1) % 16);
    halt = 1'b0;
    run_sw = 1'b0;
    ticks(30);

    // Randomized inputs.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 24) == 0) run_sw = ~run_sw;
      halt = ($urandom_range(0, 9) == 0);
      tick();
    end
    step_btn = 1'b0; run_sw = 1'b0; halt = 1'b0;
    ticks(30);

    // Asynchronous reset during a high phase.
    run_sw = 1'b1;
    wait_cpu_high(40);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
    check_eq("async_rst_count", {28'd0, cycle_count}, 32'd0);
    run_sw = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(10);

    // Sixteen presses wrap the 4-bit counter.
    for (int p = 0; p < 15; p++) press(10, 10);
    check_eq("count_15", {28'd0, cycle_count}, 32'd15);
    press(10, 10);
    check_eq("count_wrap", {28'd0, cycle_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
